// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the code-breaking game sequencer: peg geometry, the
// sequencer state encoding, the default game length and a small helper used
// by the scoring logic.
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned NUM_PEGS          = 4;
    localparam int unsigned COLOR_W           = 3;
    localparam int unsigned NUM_COLORS        = 1 << COLOR_W;
    localparam int unsigned SECRET_W          = NUM_PEGS * COLOR_W;
    localparam int unsigned DEFAULT_MAX_TURNS = 8;

    typedef logic [COLOR_W-1:0] peg_t;

    // Wide enough to hold 0..NUM_PEGS.
    typedef logic [2:0] count_t;

    typedef enum logic [2:0] {
        StIdle,
        StNewGame,
        StPlay,
        StScore,
        StWin,
        StLose
    } state_t;

    function automatic count_t min_count(input count_t a, input count_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/secret_lfsr.sv
// -----------------------------------------------------------------------------
// secret_lfsr
// 12-bit maximal-length Fibonacci LFSR, polynomial x^12 + x^6 + x^4 + x + 1.
// Steps on every rising clock edge; reset loads the seed, which must be
// nonzero or the register locks up at zero.
// Ports:
//   clk    in   sole clock
//   reset  in   asynchronous, active-high; loads seed
//   seed   in   12-bit reset value
//   value  out  current LFSR contents
// -----------------------------------------------------------------------------
module secret_lfsr
    import game_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SECRET_W-1:0] seed,
    output logic [SECRET_W-1:0] value
);

    logic [SECRET_W-1:0] lfsr_q;
    logic                feedback;

    assign feedback = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
    assign value    = lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= {lfsr_q[10:0], feedback};
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Turn sequencer for a four-peg, eight-colour code-breaking game. Picks a
// secret from a free-running LFSR when a game starts, captures and scores
// guesses, tracks the turn count and drives a downstream history block.
// Optional feature macro: GAME_SEQUENCER_TURN_TIMER_EN adds a per-turn timer
// that auto-submits the current guess after TURN_TIMEOUT cycles in PLAY.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   btn_new, btn_submit, btn_view   one-cycle button pulses
//   guess3..guess0                  current peg colours
//   mode                            0 = play view, 1 = history view
//   store                           pulse: history block captures the guess
//   hist_clear                      pulse: history block clears
//   turn                            current turn index
//   exact, partial, score_valid     score of last guess and its update pulse
//   win, lose                       held while the game is won / lost
//   secret_out                      secret while lost, else 0
//   timeout                         pulse when the turn timer expires
// -----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned          MAX_TURNS    = DEFAULT_MAX_TURNS,
    parameter logic [SECRET_W-1:0]  LFSR_SEED    = 12'hACE,
    parameter int unsigned          TURN_TIMEOUT = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_new,
    input  logic                btn_submit,
    input  logic                btn_view,
    input  logic [COLOR_W-1:0]  guess3,
    input  logic [COLOR_W-1:0]  guess2,
    input  logic [COLOR_W-1:0]  guess1,
    input  logic [COLOR_W-1:0]  guess0,
    output logic                mode,
    output logic                store,
    output logic                hist_clear,
    output logic [2:0]          turn,
    output logic [2:0]          exact,
    output logic [2:0]          partial,
    output logic                score_valid,
    output logic                win,
    output logic                lose,
    output logic [SECRET_W-1:0] secret_out,
    output logic                timeout
);

    state_t              state_q;
    logic [SECRET_W-1:0] secret_q;
    logic [SECRET_W-1:0] guess_q;
    logic [SECRET_W-1:0] lfsr_value;

    count_t              exact_c;
    count_t              partial_c;
    count_t              match_sum;
    count_t              cnt_g;
    count_t              cnt_s;

    logic                timer_fire;
    logic                take_guess;
    logic                go_new;

    secret_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    // Scoring of the captured guess against the secret; only consumed in SCORE.
    always_comb begin
        exact_c   = '0;
        match_sum = '0;
        cnt_g     = '0;
        cnt_s     = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess_q[i*COLOR_W +: COLOR_W] == secret_q[i*COLOR_W +: COLOR_W]) begin
                exact_c = exact_c + count_t'(1);
            end
        end
        // Colour-wise overlap counts exact hits too; subtract them afterwards.
        for (int c = 0; c < NUM_COLORS; c++) begin
            cnt_g = '0;
            cnt_s = '0;
            for (int i = 0; i < NUM_PEGS; i++) begin
                if (guess_q[i*COLOR_W +: COLOR_W] == peg_t'(c)) begin
                    cnt_g = cnt_g + count_t'(1);
                end
                if (secret_q[i*COLOR_W +: COLOR_W] == peg_t'(c)) begin
                    cnt_s = cnt_s + count_t'(1);
                end
            end
            match_sum = match_sum + min_count(cnt_g, cnt_s);
        end
        partial_c = match_sum - exact_c;
    end

`ifdef GAME_SEQUENCER_TURN_TIMER_EN
    localparam int unsigned TIMER_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

    logic [TIMER_W-1:0] timer_q;

    // Every entry into PLAY comes from NEWGAME or SCORE, which clear the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            case (state_q)
                StPlay:        timer_q <= timer_q + TIMER_W'(1);
                StWin, StLose: timer_q <= timer_q;
                default:       timer_q <= '0;
            endcase
        end
    end

    assign timer_fire = (state_q == StPlay) && (timer_q == TIMER_W'(TURN_TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TURN_TIMEOUT == 0);
    assign timer_fire         = 1'b0;
`endif

    // Timer expiry submits even in history view.
    assign take_guess = (btn_submit && !mode) || timer_fire;
    assign go_new     = btn_new && (state_q != StNewGame);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            secret_q    <= '0;
            guess_q     <= '0;
            mode        <= 1'b0;
            store       <= 1'b0;
            hist_clear  <= 1'b0;
            turn        <= '0;
            exact       <= '0;
            partial     <= '0;
            score_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            secret_out  <= '0;
            timeout     <= 1'b0;
        end else begin
            store       <= 1'b0;
            hist_clear  <= 1'b0;
            score_valid <= 1'b0;
            timeout     <= 1'b0;

            if (go_new) begin
                // Start or abort: takes priority over any other button.
                state_q    <= StNewGame;
                hist_clear <= 1'b1;
                mode       <= 1'b0;
                turn       <= '0;
                exact      <= '0;
                partial    <= '0;
                win        <= 1'b0;
                lose       <= 1'b0;
                secret_out <= '0;
            end else begin
                case (state_q)
                    StIdle: ;
                    StNewGame: begin
                        secret_q <= lfsr_value;
                        state_q  <= StPlay;
                    end
                    StPlay: begin
                        if (take_guess) begin
                            guess_q <= {guess3, guess2, guess1, guess0};
                            store   <= 1'b1;
                            timeout <= timer_fire;
                            state_q <= StScore;
                        end else if (btn_view) begin
                            mode <= ~mode;
                        end
                    end
                    StScore: begin
                        exact       <= exact_c;
                        partial     <= partial_c;
                        score_valid <= 1'b1;
                        if (exact_c == count_t'(NUM_PEGS)) begin
                            win     <= 1'b1;
                            state_q <= StWin;
                        end else if (turn == 3'(MAX_TURNS - 1)) begin
                            lose       <= 1'b1;
                            secret_out <= secret_q;
                            state_q    <= StLose;
                        end else begin
                            turn    <= turn + 3'd1;
                            mode    <= 1'b0;
                            state_q <= StPlay;
                        end
                    end
                    StWin, StLose: begin
                        if (btn_view) begin
                            mode <= ~mode;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
    import game_pkg::*;

    localparam logic [11:0] SEED   = 12'hACE;
    // Secret {3,1,4,1} packed as {s3,s2,s1,s0}.
    localparam logic [11:0] TARGET = 12'h661;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_new, btn_submit, btn_view;
    logic [2:0] guess3, guess2, guess1, guess0;
    logic       mode, store, hist_clear, score_valid, win, lose, timeout;
    logic [2:0] turn, exact, partial;
    logic [11:0] secret_out;

    always #5 clk = ~clk;

    game_sequencer #(
        .MAX_TURNS    (8),
        .LFSR_SEED    (SEED),
        .TURN_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_new     (btn_new),
        .btn_submit  (btn_submit),
        .btn_view    (btn_view),
        .guess3      (guess3),
        .guess2      (guess2),
        .guess1      (guess1),
        .guess0      (guess0),
        .mode        (mode),
        .store       (store),
        .hist_clear  (hist_clear),
        .turn        (turn),
        .exact       (exact),
        .partial     (partial),
        .score_valid (score_valid),
        .win         (win),
        .lose        (lose),
        .secret_out  (secret_out),
        .timeout     (timeout)
    );

    typedef struct {
        int exact;
        int partial;
        int turn;
        int win;
        int lose;
        int secret;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks      = 0;
    int   n_fail        = 0;
    int   store_count   = 0;
    int   timeout_count = 0;
    logic [11:0] lfsr_m;

    function automatic logic [11:0] lfsr_step(input logic [11:0] v);
        return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
    endfunction

    // Reference generator tracking the DUT's secret source cycle by cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv,
                     expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a score.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (store)   store_count++;
                if (timeout) timeout_count++;
                if (score_valid) begin
                    exp_t e;
                    if (exp_q.size() == 0) begin
                        check("unexpected_score_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("score_exact", int'(exact), e.exact);
                        check("score_partial", int'(partial), e.partial);
                        check("score_turn", int'(turn), e.turn);
                        check("score_win", int'(win), e.win);
                        check("score_lose", int'(lose), e.lose);
                        check("score_secret_out", int'(secret_out), e.secret);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mode"}, int'(mode), 0);
        check({tag, "_store"}, int'(store), 0);
        check({tag, "_hist_clear"}, int'(hist_clear), 0);
        check({tag, "_turn"}, int'(turn), 0);
        check({tag, "_exact"}, int'(exact), 0);
        check({tag, "_partial"}, int'(partial), 0);
        check({tag, "_score_valid"}, int'(score_valid), 0);
        check({tag, "_win"}, int'(win), 0);
        check({tag, "_lose"}, int'(lose), 0);
        check({tag, "_secret_out"}, int'(secret_out), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Called just after a negedge; returns at the first PLAY cycle.
    task automatic start_game(input logic [11:0] target);
        int n = 0;
        while (lfsr_step(lfsr_m) != target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("lfsr_wait_in_budget", int'(n < 5000), 1);
        btn_new = 1'b1;
        @(negedge clk);
        btn_new = 1'b0;
        check("newgame_hist_clear", int'(hist_clear), 1);
        check("newgame_turn", int'(turn), 0);
        check("newgame_mode", int'(mode), 0);
        @(negedge clk);
        check("play_hist_clear_low", int'(hist_clear), 0);
    endtask

    // Submits a guess; returns at the cycle where the score is presented.
    task automatic do_guess(input int g3, input int g2, input int g1, input int g0,
                            input int ex, input int pa, input int tn, input int w,
                            input int l, input int sec);
        exp_t e;
        e.exact   = ex;
        e.partial = pa;
        e.turn    = tn;
        e.win     = w;
        e.lose    = l;
        e.secret  = sec;
        exp_q.push_back(e);
        guess3     = 3'(g3);
        guess2     = 3'(g2);
        guess1     = 3'(g1);
        guess0     = 3'(g0);
        btn_submit = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        check("store_after_submit", int'(store), 1);
        @(negedge clk);
    endtask

    initial begin
        int sc0;
        reset      = 1'b1;
        btn_new    = 1'b0;
        btn_submit = 1'b0;
        btn_view   = 1'b0;
        guess3     = '0;
        guess2     = '0;
        guess1     = '0;
        guess0     = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // IDLE ignores submit and view.
        btn_submit = 1'b1;
        btn_view   = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        btn_view   = 1'b0;
        @(negedge clk);
        check("idle_ignore_store", int'(store), 0);
        check("idle_ignore_mode", int'(mode), 0);

        // Game A: scoring patterns then a win.
        start_game(TARGET);
        do_guess(1, 3, 1, 4, 0, 4, 1, 0, 0, 0);
        do_guess(3, 3, 3, 3, 1, 0, 2, 0, 0, 0);
        do_guess(4, 3, 1, 1, 1, 3, 3, 0, 0, 0);
        do_guess(3, 1, 4, 1, 4, 0, 3, 1, 0, 0);
        check("win_level", int'(win), 1);
        btn_submit = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        check("win_submit_ignored", int'(store), 0);
        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("win_view_toggle_on", int'(mode), 1);
        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("win_view_toggle_off", int'(mode), 0);
        check("win_held", int'(win), 1);

        // Game B: view/submit interaction, abort during SCORE, reset in PLAY.
        start_game(TARGET);
        check("newgame_win_cleared", int'(win), 0);
        exp_q.push_back('{0, 0, 1, 0, 0, 0});
        guess3     = 3'd0;
        guess2     = 3'd0;
        guess1     = 3'd0;
        guess0     = 3'd0;
        btn_submit = 1'b1;
        btn_view   = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        btn_view   = 1'b0;
        check("submit_view_store", int'(store), 1);
        check("submit_view_mode", int'(mode), 0);
        @(negedge clk);
        check("submit_view_mode_after", int'(mode), 0);

        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("view_alone_mode", int'(mode), 1);
        btn_submit = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        check("history_submit_no_store", int'(store), 0);
        @(negedge clk);
        check("history_submit_no_store2", int'(store), 0);
        check("history_mode_kept", int'(mode), 1);
        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("view_back_mode", int'(mode), 0);

        guess3     = 3'd7;
        guess2     = 3'd6;
        guess1     = 3'd5;
        guess0     = 3'd2;
        btn_submit = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        check("abort_store", int'(store), 1);
        btn_new = 1'b1;
        @(negedge clk);
        btn_new = 1'b0;
        check("abort_hist_clear", int'(hist_clear), 1);
        check("abort_turn", int'(turn), 0);
        check("abort_no_score", int'(score_valid), 0);
        @(negedge clk);
        check("abort_hist_clear_low", int'(hist_clear), 0);

        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("pre_reset_mode", int'(mode), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_hist_clear", int'(hist_clear), 0);
        end
        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("post_reset_idle_view", int'(mode), 0);

        // Game C: eight wrong guesses end in LOSE.
        start_game(TARGET);
        sc0 = store_count;
        do_guess(1, 3, 1, 4, 0, 4, 1, 0, 0, 0);
        do_guess(3, 3, 3, 3, 1, 0, 2, 0, 0, 0);
        do_guess(4, 3, 1, 1, 1, 3, 3, 0, 0, 0);
        do_guess(1, 1, 1, 1, 2, 0, 4, 0, 0, 0);
        do_guess(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        do_guess(7, 6, 5, 2, 0, 0, 6, 0, 0, 0);
        do_guess(3, 1, 4, 0, 3, 0, 7, 0, 0, 0);
        do_guess(3, 1, 1, 4, 2, 2, 7, 0, 1, int'(TARGET));
        check("lose_level", int'(lose), 1);
        check("lose_secret_out", int'(secret_out), int'(TARGET));
        check("lose_turn", int'(turn), 7);
        check("lose_store_pulses", store_count - sc0, 8);
        btn_view = 1'b1;
        @(negedge clk);
        btn_view = 1'b0;
        check("lose_view_toggle", int'(mode), 1);
        check("lose_secret_held", int'(secret_out), int'(TARGET));
        btn_submit = 1'b1;
        @(negedge clk);
        btn_submit = 1'b0;
        check("lose_submit_ignored", int'(store), 0);

        // Game D: leaving LOSE, then turn-timer behaviour.
        start_game(TARGET);
        check("newgame_lose_cleared", int'(lose), 0);
        check("newgame_secret_out_cleared", int'(secret_out), 0);
        guess3 = 3'd0;
        guess2 = 3'd0;
        guess1 = 3'd0;
        guess0 = 3'd0;
`ifdef GAME_SEQUENCER_TURN_TIMER_EN
        begin
            int n = 0;
            exp_q.push_back('{0, 0, 1, 0, 0, 0});
            while (!timeout && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycle", n, 16);
            check("timeout_store", int'(store), 1);
            @(negedge clk);
        end
`else
        sc0 = store_count;
        repeat (24) @(negedge clk);
        check("no_timer_store", store_count - sc0, 0);
        check("no_timeout_ever", timeout_count, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
